// File: rtl/scr1_tapc_clk_sync.sv
// scr1_tapc_clk_sync: oversamples the JTAG TAP chain interface in the clk domain and
// emits single-cycle capture/shift/update pulses to the DMI, returning TDO on TCK fall.
// Revision: 1.0
`default_nettype none

module scr1_tapc_clk_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CH_ID_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tapc_tck_i,
  input  logic               tapc_trst_n_i,
  input  logic               tapc_ch_sel_i,
  input  logic [CH_ID_W-1:0] tapc_ch_id_i,
  input  logic               tapc_ch_capture_i,
  input  logic               tapc_ch_shift_i,
  input  logic               tapc_ch_update_i,
  input  logic               tapc_ch_tdi_i,
  output logic               tapc_ch_tdo_o,
  output logic               tapcsync2dmi_ch_sel_o,
  output logic [CH_ID_W-1:0] tapcsync2dmi_ch_id_o,
  output logic               tapcsync2dmi_ch_capture_o,
  output logic               tapcsync2dmi_ch_shift_o,
  output logic               tapcsync2dmi_ch_update_o,
  output logic               tapcsync2dmi_ch_tdi_o,
  input  logic               dmi2tapcsync_ch_tdo_i
);

  // Vector layout: {tck, sel, id, capture, shift, update, tdi}
  localparam int PW      = CH_ID_W + 6;
  localparam int B_TDI   = 0;
  localparam int B_UPD   = 1;
  localparam int B_SHIFT = 2;
  localparam int B_CAP   = 3;
  localparam int B_ID    = 4;
  localparam int B_SEL   = PW - 2;
  localparam int B_TCK   = PW - 1;

  logic [PW-1:0]                  pin_vec;
  logic [SYNC_STAGES-1:0]         trst_ff;
  logic                           trst_sync_n;
  logic [SYNC_STAGES-1:0][PW-1:0] s_sync;
  logic [PW-1:0]                  s_last;
  logic [PW-1:0]                  h1;
  logic [PW-1:0]                  h2;
  logic                           tck_rise;
  logic                           tck_fall;

  assign pin_vec = {tapc_tck_i, tapc_ch_sel_i, tapc_ch_id_i, tapc_ch_capture_i,
                    tapc_ch_shift_i, tapc_ch_update_i, tapc_ch_tdi_i};

  // TAP reset: asserts asynchronously, releases through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n or negedge tapc_trst_n_i) begin
    if (!rst_n || !tapc_trst_n_i) begin
      trst_ff <= '0;
    end else begin
      trst_ff <= {trst_ff[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign trst_sync_n = trst_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync <= '0;
      h1     <= '0;
      h2     <= '0;
    end else if (!trst_sync_n) begin
      s_sync <= '0;
      h1     <= '0;
      h2     <= '0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], pin_vec};
      h1     <= s_sync[SYNC_STAGES-1];
      h2     <= h1;
    end
  end

  assign s_last   = s_sync[SYNC_STAGES-1];
  assign tck_rise =  s_last[B_TCK] & ~h1[B_TCK];
  assign tck_fall = ~s_last[B_TCK] &  h1[B_TCK];

  // Rise pulses take controls from h2, one sample older than the edge, to absorb
  // a cycle of skew between the TCK and control synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tapcsync2dmi_ch_capture_o <= 1'b0;
      tapcsync2dmi_ch_shift_o   <= 1'b0;
      tapcsync2dmi_ch_update_o  <= 1'b0;
      tapcsync2dmi_ch_tdi_o     <= 1'b0;
      tapcsync2dmi_ch_sel_o     <= 1'b0;
      tapcsync2dmi_ch_id_o      <= '0;
      tapc_ch_tdo_o             <= 1'b0;
    end else if (!trst_sync_n) begin
      tapcsync2dmi_ch_capture_o <= 1'b0;
      tapcsync2dmi_ch_shift_o   <= 1'b0;
      tapcsync2dmi_ch_update_o  <= 1'b0;
      tapcsync2dmi_ch_tdi_o     <= 1'b0;
      tapcsync2dmi_ch_sel_o     <= 1'b0;
      tapcsync2dmi_ch_id_o      <= '0;
      tapc_ch_tdo_o             <= 1'b0;
    end else begin
      tapcsync2dmi_ch_capture_o <= tck_rise & h2[B_CAP] & h2[B_SEL];
      tapcsync2dmi_ch_shift_o   <= tck_rise & h2[B_SHIFT] & h2[B_SEL] & ~h2[B_CAP];
      tapcsync2dmi_ch_update_o  <= tck_fall & h1[B_UPD] & h1[B_SEL];
      tapcsync2dmi_ch_sel_o     <= h2[B_SEL];
      tapcsync2dmi_ch_id_o      <= h2[B_ID +: CH_ID_W];
      if (tck_rise) begin
        tapcsync2dmi_ch_tdi_o <= h2[B_TDI];
      end
      // TDO moves only on TCK fall so it is stable across the TAP's rising-edge sample
      if (tck_fall) begin
        tapc_ch_tdo_o <= dmi2tapcsync_ch_tdo_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scr1_tapc_clk_sync.sv
// tb_scr1_tapc_clk_sync: directed TCK sequences with a pulse scoreboard for scr1_tapc_clk_sync.
// Revision: 1.0
`default_nettype none

module tb_scr1_tapc_clk_sync;

  localparam int SS  = 2;
  localparam int IDW = 2;
  localparam logic [2:0] K_CAP = 3'b100;
  localparam logic [2:0] K_SHF = 3'b010;
  localparam logic [2:0] K_UPD = 3'b001;

  typedef struct {
    logic [2:0]     kind;
    logic           tdi;
    logic [IDW-1:0] id;
    int             edge_cyc;
  } item_t;

  logic           clk;
  logic           rst_n;
  logic           tck;
  logic           trst_n;
  logic           sel;
  logic [IDW-1:0] id;
  logic           cap;
  logic           shf;
  logic           upd;
  logic           tdi;
  logic           tdo_o;
  logic           sel_o;
  logic [IDW-1:0] id_o;
  logic           cap_o;
  logic           shf_o;
  logic           upd_o;
  logic           tdi_o;
  logic           dmi_tdo;

  item_t exp_q[$];
  item_t e;
  int    cyc;
  int    lat;
  int    errors;
  int    checks;
  logic  exp_tdo;

  scr1_tapc_clk_sync #(.SYNC_STAGES(SS), .CH_ID_W(IDW)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .tapc_tck_i                (tck),
    .tapc_trst_n_i             (trst_n),
    .tapc_ch_sel_i             (sel),
    .tapc_ch_id_i              (id),
    .tapc_ch_capture_i         (cap),
    .tapc_ch_shift_i           (shf),
    .tapc_ch_update_i          (upd),
    .tapc_ch_tdi_i             (tdi),
    .tapc_ch_tdo_o             (tdo_o),
    .tapcsync2dmi_ch_sel_o     (sel_o),
    .tapcsync2dmi_ch_id_o      (id_o),
    .tapcsync2dmi_ch_capture_o (cap_o),
    .tapcsync2dmi_ch_shift_o   (shf_o),
    .tapcsync2dmi_ch_update_o  (upd_o),
    .tapcsync2dmi_ch_tdi_o     (tdi_o),
    .dmi2tapcsync_ch_tdo_i     (dmi_tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic d);
    item_t it;
    it.kind     = k;
    it.tdi      = d;
    it.id       = id;
    it.edge_cyc = cyc;
    exp_q.push_back(it);
  endtask

  // One TCK period, starting and ending with TCK low; update is raised after the rise
  task automatic tck_cycle(input logic s, input logic c, input logic sh, input logic u,
                           input logic d, input int lo, input int hi, input bit en);
    sel = s; cap = c; shf = sh; tdi = d; upd = 1'b0;
    repeat (lo) @(negedge clk);
    tck = 1'b1;
    if (en && s && c) push(K_CAP, d);
    else if (en && s && sh) push(K_SHF, d);
    @(negedge clk);
    upd = u;
    repeat (hi - 1) @(negedge clk);
    tck = 1'b0;
    if (en && s && u) push(K_UPD, 1'b0);
    if (rst_n && trst_n) exp_tdo = dmi_tdo;
  endtask

  // Scoreboard monitor: every presented pulse must match the oldest expectation
  always @(negedge clk) begin
    if (cap_o || shf_o || upd_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got cap/shf/upd=%b, required no pulse (cycle %0d)",
                 {cap_o, shf_o, upd_o}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", int'({cap_o, shf_o, upd_o}), int'(e.kind));
        check("id_o", int'(id_o), int'(e.id));
        if (e.kind == K_SHF) check("tdi_o", int'(tdi_o), int'(e.tdi));
        lat = cyc - e.edge_cyc;
        checks++;
        if (lat < SS + 1 || lat > SS + 2) begin
          errors++;
          $display("FAIL pulse_latency: got %0d clk, required %0d..%0d", lat, SS + 1, SS + 2);
        end
      end
    end
  end

  initial begin
    logic [7:0] pat;
    logic [3:0] tdo_seq;
    errors = 0; checks = 0; exp_tdo = 1'b0;
    rst_n = 1'b0; trst_n = 1'b1; tck = 1'b0;
    sel = 1'b0; id = 2'd2; cap = 1'b0; shf = 1'b0; upd = 1'b0; tdi = 1'b0; dmi_tdo = 1'b0;
    pat = 8'hA5;
    tdo_seq = 4'b1101;

    // Reset held: TCK activity with sel/shift must not disturb any output
    for (int i = 0; i < 3; i++) begin
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6, 6, 1'b0);
      check("reset_outputs", int'({cap_o, shf_o, upd_o, sel_o, id_o, tdi_o, tdo_o}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_pulses", int'({cap_o, shf_o, upd_o}), 0);

    // Capture once, then 41 shifts of the 0xA5 pattern, LSB first
    tck_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 8, 1'b1);
    for (int i = 0; i < 41; i++)
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b0, pat[i % 8], 8, 8, 1'b1);
    check("sel_o_level", int'(sel_o), 1);

    // Update with and without chain select
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8, 8, 1'b1);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 8, 1'b1);
    repeat (8) @(negedge clk);
    check("sel_o_low", int'(sel_o), 0);

    // TAP reset during a shift run
    dmi_tdo = 1'b1;
    for (int i = 0; i < 9; i++)
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b0, pat[i % 8], 8, 8, 1'b1);
    check("tdo_before_trst", int'(tdo_o), 1);
    trst_n = 1'b0;
    exp_tdo = 1'b0;
    repeat (2) @(negedge clk);
    check("trst_tdo", int'(tdo_o), 0);
    for (int i = 0; i < 3; i++) begin
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8, 8, 1'b0);
      check("trst_sel_o", int'(sel_o), 0);
      check("trst_tdo_hold", int'(tdo_o), 0);
    end
    trst_n = 1'b1;
    dmi_tdo = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++)
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b0, pat[(i + 3) % 8], 8, 8, 1'b1);
    check("tdo_after_trst", int'(tdo_o), int'(exp_tdo));

    // TDO: DMI value changes after each shift pulse, appears only after the fall
    for (int k = 0; k < 4; k++) begin
      sel = 1'b1; cap = 1'b0; shf = 1'b1; upd = 1'b0; tdi = 1'b0;
      repeat (8) @(negedge clk);
      tck = 1'b1;
      push(K_SHF, 1'b0);
      repeat (SS + 3) @(negedge clk);
      dmi_tdo = tdo_seq[k];
      repeat (2) @(negedge clk);
      check("tdo_hold_high_phase", int'(tdo_o), int'(exp_tdo));
      repeat (8 - (SS + 5)) @(negedge clk);
      tck = 1'b0;
      exp_tdo = dmi_tdo;
      repeat (SS + 3) @(negedge clk);
      check("tdo_after_fall", int'(tdo_o), int'(tdo_seq[k]));
    end

    // Minimum legal phase width, 100 shifts
    for (int i = 0; i < 100; i++)
      tck_cycle(1'b1, 1'b0, 1'b1, 1'b0, pat[(i * 3) % 8], SS + 2, SS + 2, 1'b1);

    repeat (20) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
